param_assoc_cache: RTL and testbench
====================================

PARAM_ASSOC_CACHE -- requirements
Module: param_assoc_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameter WAYS, default 2, associativity; power of 2, 1..8.
REQ-004 SHALL have parameter SETS, default 4, set count; power of 2.
REQ-005 SHALL have parameter LINE_WORDS, default 4, words per line; power of 2.
REQ-006 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port cpu_req, input, 1, request strobe; sampled only when stall=0.
REQ-009 SHALL have port cpu_we, input, 1, 1=write, 0=read.
REQ-010 SHALL have port cpu_addr, input, ADDR_W, word address.
REQ-011 SHALL have port cpu_wdata, input, DATA_W, write data.
REQ-012 SHALL have port cpu_rdata, output, DATA_W, read data; valid only while cpu_valid=1.
REQ-013 SHALL have port cpu_valid, output, 1, one-cycle completion pulse for read or write.
REQ-014 SHALL have port stall, output, 1, busy; high whenever FSM is not IDLE.
REQ-015 SHALL have port mem_req, output, 1, memory request; held until mem_ack.
REQ-016 SHALL have port mem_we, output, 1, memory write qualifier.
REQ-017 SHALL have port mem_addr, output, ADDR_W, word address for writes, line base (offset zeroed) for refills.
REQ-018 SHALL have port mem_wdata, output, DATA_W, write-through data.
REQ-019 SHALL have port mem_ack, input, 1, one-cycle memory completion.
REQ-020 SHALL have port mem_rdata, input, DATA_W*LINE_WORDS, refill line; word 0 in LSBs; valid with mem_ack.
REQ-021 SHALL have ports hit_cnt and miss_cnt, output, 16 each, saturating lookup statistics.

Function
REQ-022 SHALL split the address LSB-first into offset (log2 LINE_WORDS), index (log2 SETS), and tag (remaining bits).
REQ-023 SHALL implement FSM states IDLE, LOOKUP, REFILL, WRITE, RESP.
REQ-024 SHALL, in IDLE with cpu_req=1, register we/addr/wdata and go to LOOKUP; cpu_req while stall=1 SHALL be ignored, not queued.
REQ-025 SHALL, on LOOKUP read hit, assert cpu_valid with the hit word in that cycle (one cycle after acceptance), increment hit_cnt, update PLRU, and return to IDLE.
REQ-026 SHALL, on LOOKUP read miss, increment miss_cnt and enter REFILL with mem_req=1, mem_we=0.
REQ-027 SHALL, on the REFILL mem_ack cycle, write the line into the victim way, set valid and tag, update PLRU, and enter RESP.
REQ-028 SHALL, in RESP, pulse cpu_valid with the requested word, then go to IDLE.
REQ-029 SHALL choose the victim as the lowest-index invalid way, otherwise the tree-PLRU way of the set.
REQ-030 SHALL use write-through, no-write-allocate for writes.
REQ-031 SHALL handle a write hit: count a hit, update the cached word and PLRU in LOOKUP, then go to WRITE.
REQ-032 SHALL handle a write miss: count a miss, change no tag/valid/PLRU state, then go to WRITE.
REQ-033 SHALL, in WRITE, drive mem_req=1, mem_we=1 with the full word address and data until mem_ack, then pulse cpu_valid and go to IDLE.
REQ-034 SHALL ignore mem_ack outside REFILL/WRITE; mem_* outputs SHALL be stable while mem_req=1.
REQ-035 SHALL saturate hit_cnt and miss_cnt at 0xFFFF with no wrap.

Reset
REQ-036 SHALL, on reset=0 (asynchronous, including mid-REFILL/WRITE), force state IDLE, clear all valid and PLRU bits, and zero the counters.
REQ-037 SHALL, on reset=0, force cpu_valid, stall, mem_req, mem_we, mem_addr, mem_wdata, and cpu_rdata to 0; a late mem_ack after reset SHALL be ignored.
REQ-038 SHALL leave data/tag arrays uncleared on reset.

Structure
REQ-039 SHALL keep the FSM state typedef and the PLRU update/victim functions in shared package cache_pkg.
REQ-040 SHALL place per-set PLRU storage and victim logic in sub-module cache_plru; widths are derived by $clog2 from parameters.

Verification (defaults; index=addr[3:2])
REQ-041 SHALL cover cold read: after reset, read 0x05 -> mem_req, mem_addr=0x04; ack line {0x33,0x22,0x11,0x00} -> RESP cpu_rdata=0x11, miss_cnt=1.
REQ-042 SHALL cover read hit: then read 0x06 -> cpu_valid one cycle after acceptance, cpu_rdata=0x22, no mem_req, hit_cnt=1.
REQ-043 SHALL cover PLRU eviction: reads 0x14 (miss), 0x04 (hit), 0x24 (miss) -> tag 1 evicted; then 0x04 hits and 0x14 misses.
REQ-044 SHALL cover writes: write 0x05=0xDEADBEEF with ack delayed 3 cycles -> mem_we=1, stall held, then cpu_valid; read 0x05 hits 0xDEADBEEF; write miss 0x3C then read 0x3C -> miss.
REQ-045 SHALL cover reset mid-REFILL: reset=0 before ack -> mem_req=0, stall=0 immediately; a late ack is ignored; re-read of a previously cached address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state encoding and tree-PLRU helpers for param_assoc_cache
//
// Purpose: state constants used by the cache FSM, plus pure functions that
// update and query a tree pseudo-LRU word for up to 8 ways.
// Ports: none (package).
package cache_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOOKUP = 3'd1;
  localparam state_t ST_REFILL = 3'd2;
  localparam state_t ST_WRITE  = 3'd3;
  localparam state_t ST_RESP   = 3'd4;

  // Tree of up to 7 nodes (8 ways). Node n has children 2n+1 (left) and
  // 2n+2 (right). A node bit of 0 points the victim search left, 1 right.
  localparam int PLRU_MAX_BITS = 7;
  localparam int WAY_MAX_W     = 3;

  typedef logic [PLRU_MAX_BITS-1:0] plru_t;

  // On an access, every node on the path is pointed away from the used way.
  function automatic plru_t plru_touch(input plru_t bits, input logic [2:0] way,
                                       input int levels);
    plru_t nb;
    int    node;
    logic  b;
    nb   = bits;
    node = 0;
    for (int l = 0; l < WAY_MAX_W; l++) begin
      if (l < levels) begin
        b        = way[levels-1-l];
        nb[node] = ~b;
        node     = 2 * node + (b ? 2 : 1);
      end
    end
    return nb;
  endfunction

  // Follows the node bits from the root; the first decision is the way MSB.
  function automatic logic [2:0] plru_victim(input plru_t bits, input int levels);
    logic [2:0] w;
    int         node;
    w    = '0;
    node = 0;
    for (int l = 0; l < WAY_MAX_W; l++) begin
      if (l < levels) begin
        w    = {w[1:0], bits[node]};
        node = 2 * node + (bits[node] ? 2 : 1);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// rtl/cache_plru.sv - per-set tree-PLRU storage and victim selection
//
// Purpose: holds one PLRU word per set, updates it on touch, and picks the
// replacement way (lowest invalid way first, otherwise the PLRU way).
// Ports:
//   clk, reset       clock, asynchronous active-low reset (clears all PLRU bits)
//   set_idx          set being looked up / updated
//   valid_vec        valid bits of the ways in set_idx
//   touch_en/way     mark a way of set_idx as most recently used
//   victim           way to replace in set_idx
module cache_plru
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 4,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic             touch_en,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim
);

  localparam int PW     = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int LEVELS = $clog2(WAYS);

  logic [PW-1:0] plru_mem [SETS];
  plru_t         cur;
  plru_t         nxt;

  assign cur = plru_t'(plru_mem[set_idx]);
  assign nxt = plru_touch(cur, 3'(touch_way), LEVELS);

  always_comb begin
    victim = WAY_W'(plru_victim(cur, LEVELS));
    // Scan downward so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) victim = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) plru_mem[s] <= '0;
    end else if (touch_en) begin
      plru_mem[set_idx] <= nxt[PW-1:0];
    end
  end

endmodule

// File: rtl/param_assoc_cache.sv
// rtl/param_assoc_cache.sv - parameterised set-associative write-through read cache
//
// Purpose: blocking single-request cache, write-through / no-write-allocate,
// full-line refill, tree-PLRU replacement, saturating hit/miss counters.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       request, accepted only while stall=0
//   cpu_rdata, cpu_valid        one-cycle completion pulse with read data
//   stall                       high whenever the FSM is not idle
//   mem_req/we/addr/wdata       memory request, held stable until mem_ack
//   mem_ack, mem_rdata          memory completion; refill line, word 0 in LSBs
//   hit_cnt, miss_cnt           saturating lookup statistics
module param_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_valid,
  output logic                         stall,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ack,
  input  logic [DATA_W*LINE_WORDS-1:0] mem_rdata,
  output logic [15:0]                  hit_cnt,
  output logic [15:0]                  miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t              state;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [WAY_W-1:0]    victim_q;
  logic [DATA_W-1:0]   resp_word;

  // Data and tags are deliberately not reset; valid bits gate their use.
  logic [DATA_W-1:0]   data_mem [SETS][WAYS][LINE_WORDS];
  logic [TAG_W-1:0]    tag_mem  [SETS][WAYS];
  logic [WAYS-1:0]     valid_q  [SETS];

  logic [OFF_W-1:0]    req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [DATA_W-1:0]   hit_word;
  logic [WAY_W-1:0]    victim;
  logic                lookup_rd_hit;
  logic                refill_done;
  logic                plru_touch_en;
  logic [WAY_W-1:0]    plru_touch_way;

  assign req_off = req_addr[OFF_W-1:0];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_word      = data_mem[req_idx][hit_way][req_off];
  assign lookup_rd_hit = (state == ST_LOOKUP) && hit && !req_we;
  assign refill_done   = (state == ST_REFILL) && mem_ack;

  // Completion outputs are decoded from state so reset clears them at once.
  assign stall     = (state != ST_IDLE);
  assign cpu_valid = lookup_rd_hit || (state == ST_RESP) || ((state == ST_WRITE) && mem_ack);
  assign cpu_rdata = lookup_rd_hit ? hit_word : ((state == ST_RESP) ? resp_word : '0);

  assign plru_touch_en  = ((state == ST_LOOKUP) && hit) || refill_done;
  assign plru_touch_way = refill_done ? victim_q : hit_way;

  cache_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk       (clk),
    .reset     (reset),
    .set_idx   (req_idx),
    .valid_vec (valid_q[req_idx]),
    .touch_en  (plru_touch_en),
    .touch_way (plru_touch_way),
    .victim    (victim)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      victim_q  <= '0;
      resp_word <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          victim_q <= victim;
          if (hit) begin
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
          end else begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
          end
          if (req_we) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            state     <= ST_WRITE;
          end else if (hit) begin
            state <= ST_IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            state    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (mem_ack) begin
            mem_req                     <= 1'b0;
            valid_q[req_idx][victim_q]  <= 1'b1;
            resp_word                   <= mem_rdata[int'(req_off)*DATA_W +: DATA_W];
            state                       <= ST_RESP;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_LOOKUP) && hit && req_we) begin
      data_mem[req_idx][hit_way][req_off] <= req_wdata;
    end
    if (refill_done) begin
      tag_mem[req_idx][victim_q] <= req_tag;
      for (int i = 0; i < LINE_WORDS; i++) begin
        data_mem[req_idx][victim_q][i] <= mem_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_param_assoc_cache.sv
// tb/tb_param_assoc_cache.sv - directed self-checking bench for param_assoc_cache
module tb_param_assoc_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic         cpu_we;
  logic [5:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_valid;
  logic         stall;
  logic         mem_req;
  logic         mem_we;
  logic [5:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  param_assoc_cache dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_valid (cpu_valid),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_word(input logic [5:0] base, input int i);
    return 32'hC0DE_0000 | (32'(base) << 8) | 32'(i);
  endfunction

  function automatic logic [127:0] mk_line(input logic [5:0] base);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = mk_word(base, i);
    return l;
  endfunction

  // Called just after a rising edge with the DUT idle; returns in LOOKUP.
  task automatic issue(input logic we, input logic [5:0] addr, input logic [31:0] wd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
  endtask

  task automatic read_hit(input logic [5:0] addr, input logic [31:0] exp);
    issue(1'b0, addr, 32'h0);
    check("rd_hit_valid", 64'(cpu_valid), 64'd1);
    check("rd_hit_data", 64'(cpu_rdata), 64'(exp));
    check("rd_hit_no_mem_req", 64'(mem_req), 64'd0);
    @(posedge clk); #1;
    check("rd_hit_idle", 64'(stall), 64'd0);
  endtask

  task automatic read_miss(input logic [5:0] addr, input logic [127:0] line, input logic [31:0] exp);
    issue(1'b0, addr, 32'h0);
    check("rd_miss_lookup_valid", 64'(cpu_valid), 64'd0);
    @(posedge clk); #1;
    check("refill_mem_req", 64'(mem_req), 64'd1);
    check("refill_mem_we", 64'(mem_we), 64'd0);
    check("refill_mem_addr", 64'(mem_addr), 64'({addr[5:2], 2'b00}));
    check("refill_stall", 64'(stall), 64'd1);
    // A request during the refill must be dropped, not queued.
    cpu_req   = 1'b1;
    cpu_addr  = 6'h3F;
    mem_rdata = line;
    mem_ack   = 1'b1;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    cpu_req   = 1'b0;
    check("resp_valid", 64'(cpu_valid), 64'd1);
    check("resp_data", 64'(cpu_rdata), 64'(exp));
    check("resp_mem_req_low", 64'(mem_req), 64'd0);
    @(posedge clk); #1;
    check("after_resp_idle", 64'(stall), 64'd0);
    check("after_resp_valid", 64'(cpu_valid), 64'd0);
  endtask

  task automatic write_op(input logic [5:0] addr, input logic [31:0] data, input int delay);
    issue(1'b1, addr, data);
    check("wr_lookup_valid", 64'(cpu_valid), 64'd0);
    @(posedge clk); #1;
    check("wr_mem_req", 64'(mem_req), 64'd1);
    check("wr_mem_we", 64'(mem_we), 64'd1);
    check("wr_mem_addr", 64'(mem_addr), 64'(addr));
    check("wr_mem_wdata", 64'(mem_wdata), 64'(data));
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      check("wr_wait_stall", 64'(stall), 64'd1);
      check("wr_wait_mem_req", 64'(mem_req), 64'd1);
      check("wr_wait_addr", 64'(mem_addr), 64'(addr));
      check("wr_wait_valid", 64'(cpu_valid), 64'd0);
    end
    mem_ack = 1'b1;
    #1;
    check("wr_done_valid", 64'(cpu_valid), 64'd1);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("wr_after_stall", 64'(stall), 64'd0);
    check("wr_after_mem_req", 64'(mem_req), 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_cpu_valid", 64'(cpu_valid), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Cold read and hit on the same line.
    read_miss(6'h05, 128'h00000033_00000022_00000011_00000000, 32'h11);
    check("cold_miss_cnt", 64'(miss_cnt), 64'd1);
    read_hit(6'h06, 32'h22);
    check("hit_cnt_1", 64'(hit_cnt), 64'd1);

    // PLRU eviction in set 1.
    read_miss(6'h14, mk_line(6'h14), mk_word(6'h14, 0));
    read_hit(6'h04, 32'h00);
    read_miss(6'h24, mk_line(6'h24), mk_word(6'h24, 0));
    read_hit(6'h04, 32'h00);
    read_miss(6'h14, mk_line(6'h14), mk_word(6'h14, 0));
    check("plru_hit_cnt", 64'(hit_cnt), 64'd3);
    check("plru_miss_cnt", 64'(miss_cnt), 64'd4);

    // Write hit with delayed ack, then read-back; write miss does not allocate.
    write_op(6'h05, 32'hDEADBEEF, 3);
    check("wr_hit_cnt", 64'(hit_cnt), 64'd4);
    read_hit(6'h05, 32'hDEADBEEF);
    read_hit(6'h06, 32'h22);
    write_op(6'h3C, 32'h12345678, 0);
    check("wr_miss_cnt", 64'(miss_cnt), 64'd5);
    read_miss(6'h3C, mk_line(6'h3C), mk_word(6'h3C, 0));
    check("final_hit_cnt", 64'(hit_cnt), 64'd6);
    check("final_miss_cnt", 64'(miss_cnt), 64'd6);

    // Reset in the middle of a refill, then a late ack.
    issue(1'b0, 6'h08, 32'h0);
    @(posedge clk); #1;
    check("mid_refill_mem_req", 64'(mem_req), 64'd1);
    reset = 1'b0;
    #1;
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_mem_addr", 64'(mem_addr), 64'd0);
    check("midrst_miss_cnt", 64'(miss_cnt), 64'd0);
    check("midrst_hit_cnt", 64'(hit_cnt), 64'd0);
    @(posedge clk); #1;
    reset     = 1'b1;
    mem_rdata = mk_line(6'h08);
    mem_ack   = 1'b1;
    #1;
    check("late_ack_valid", 64'(cpu_valid), 64'd0);
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("late_ack_stall", 64'(stall), 64'd0);
    check("late_ack_valid2", 64'(cpu_valid), 64'd0);
    read_miss(6'h05, mk_line(6'h04), mk_word(6'h04, 1));
    check("post_rst_miss_cnt", 64'(miss_cnt), 64'd1);
    check("post_rst_hit_cnt", 64'(hit_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
